// File: rtl/rs_add_bank_pkg.sv
// Shared Tomasulo definitions: widths, the tag map and the reservation-station entry layout.
package tomasulo_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  // A zero producer tag means the operand value is already present.
  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  // Tag map shared by every unit that broadcasts on the CDB.
  localparam int ADD_RS_TAG_BASE = 1;
  localparam int MUL_RS_TAG_BASE = 4;
  localparam int LD_TAG_BASE     = 6;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2
  } rs_state_t;

  typedef struct packed {
    rs_state_t         state;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] vj;
    logic [TAG_W-1:0]  qj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qk;
  } rs_entry_t;

  // True when a pending operand is produced by the current broadcast.
  function automatic logic tagHit(input logic [TAG_W-1:0] q,
                                  input logic             cdbValid,
                                  input logic [TAG_W-1:0] cdbTag);
    return cdbValid && (q != TAG_NONE) && (q == cdbTag);
  endfunction

endpackage

// File: rtl/rs_add_bank_if.sv
// Issue, CDB and dispatch signals of the adder reservation-station bank.
interface rs_add_bank_if import tomasulo_pkg::*; ();

  logic              issue_valid;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [DATA_W-1:0] issue_vj;
  logic [TAG_W-1:0]  issue_qj;
  logic [DATA_W-1:0] issue_vk;
  logic [TAG_W-1:0]  issue_qk;
  logic [TAG_W-1:0]  issue_tag;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              disp_valid;
  logic              disp_ready;
  logic [OP_W-1:0]   disp_op;
  logic [DATA_W-1:0] disp_a;
  logic [DATA_W-1:0] disp_b;
  logic [TAG_W-1:0]  disp_tag;

  // The bank side.
  modport slave (
    input  issue_valid, issue_op, issue_vj, issue_qj, issue_vk, issue_qk,
    input  cdb_valid, cdb_tag, cdb_data,
    input  disp_ready,
    output issue_ready, issue_tag,
    output disp_valid, disp_op, disp_a, disp_b, disp_tag
  );

  // The issue logic / CDB / adder side.
  modport master (
    output issue_valid, issue_op, issue_vj, issue_qj, issue_vk, issue_qk,
    output cdb_valid, cdb_tag, cdb_data,
    output disp_ready,
    input  issue_ready, issue_tag,
    input  disp_valid, disp_op, disp_a, disp_b, disp_tag
  );

endinterface

// File: rtl/rs_add_bank_slot.sv
// One reservation-station slot: operand storage, CDB snoop/bypass and free on its own tag.
module rs_slot import tomasulo_pkg::*; #(
  parameter logic [TAG_W-1:0] MY_TAG = 4'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_i,
  input  logic              dispatch_i,
  input  logic [OP_W-1:0]   issueOp_i,
  input  logic [DATA_W-1:0] issueVj_i,
  input  logic [TAG_W-1:0]  issueQj_i,
  input  logic [DATA_W-1:0] issueVk_i,
  input  logic [TAG_W-1:0]  issueQk_i,
  input  logic              cdbValid_i,
  input  logic [TAG_W-1:0]  cdbTag_i,
  input  logic [DATA_W-1:0] cdbData_i,
  output rs_entry_t         entry_o,
  output logic              eligible_o,
  output logic              busyNext_o
);

  rs_entry_t entry_q;
  rs_entry_t entry_d;

  // Next-state: allocation with same-cycle bypass, operand snoop while waiting, release on own broadcast.
  always_comb begin
    entry_d = entry_q;
    unique case (entry_q.state)
      FREE: begin
        if (alloc_i) begin
          entry_d.state = WAIT;
          entry_d.op    = issueOp_i;
          entry_d.vj    = issueVj_i;
          entry_d.qj    = issueQj_i;
          entry_d.vk    = issueVk_i;
          entry_d.qk    = issueQk_i;
          if (tagHit(issueQj_i, cdbValid_i, cdbTag_i)) begin
            entry_d.vj = cdbData_i;
            entry_d.qj = TAG_NONE;
          end
          if (tagHit(issueQk_i, cdbValid_i, cdbTag_i)) begin
            entry_d.vk = cdbData_i;
            entry_d.qk = TAG_NONE;
          end
        end
      end
      WAIT: begin
        if (tagHit(entry_q.qj, cdbValid_i, cdbTag_i)) begin
          entry_d.vj = cdbData_i;
          entry_d.qj = TAG_NONE;
        end
        if (tagHit(entry_q.qk, cdbValid_i, cdbTag_i)) begin
          entry_d.vk = cdbData_i;
          entry_d.qk = TAG_NONE;
        end
        if (dispatch_i) begin
          entry_d.state = EXEC;
        end
      end
      EXEC: begin
        if (cdbValid_i && (cdbTag_i == MY_TAG)) begin
          entry_d.state = FREE;
        end
      end
      default: entry_d.state = FREE;
    endcase
  end

  // Slot register; reset empties the slot and clears pending tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o    = entry_q;
  assign eligible_o = (entry_q.state == WAIT) && (entry_q.qj == TAG_NONE) && (entry_q.qk == TAG_NONE);
  assign busyNext_o = (entry_d.state != FREE);

endmodule

// File: rtl/rs_add_bank.sv
// Adder reservation-station bank: allocation, dispatch selection, output register and occupancy count.
module rs_add_bank #(
  parameter int NUM_ENTRIES = 3,
  parameter int TAG_BASE    = tomasulo_pkg::ADD_RS_TAG_BASE,
  parameter int DATA_W      = tomasulo_pkg::DATA_W,
  parameter int TAG_W       = tomasulo_pkg::TAG_W,
  parameter int OP_W        = tomasulo_pkg::OP_W
) (
  input  logic                               clk,
  input  logic                               reset,
  rs_add_bank_if.slave                       bus,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   busy_count
);

  import tomasulo_pkg::*;

  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  rs_entry_t               entries [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]  eligVec;
  logic [NUM_ENTRIES-1:0]  busyNextVec;
  logic [NUM_ENTRIES-1:0]  allocVec;
  logic [NUM_ENTRIES-1:0]  dispatchVec;

  logic                    hasFree;
  logic [IDX_W-1:0]        allocIdx;
  logic                    hasElig;
  logic [IDX_W-1:0]        selIdx;
  logic                    issueFire;
  logic                    loadOut;

  logic                    dispValid_q, dispValid_d;
  logic [OP_W-1:0]         dispOp_q, dispOp_d;
  logic [DATA_W-1:0]       dispA_q, dispA_d;
  logic [DATA_W-1:0]       dispB_q, dispB_d;
  logic [TAG_W-1:0]        dispTag_q, dispTag_d;
  logic [CNT_W-1:0]        busyCount_q, busyCount_d;

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : gSlot
    assign allocVec[g]    = issueFire && (allocIdx == IDX_W'(g));
    assign dispatchVec[g] = loadOut && hasElig && (selIdx == IDX_W'(g));

    rs_slot #(
      .MY_TAG(TAG_W'(TAG_BASE + g))
    ) uSlot (
      .clk        (clk),
      .reset      (reset),
      .alloc_i    (allocVec[g]),
      .dispatch_i (dispatchVec[g]),
      .issueOp_i  (bus.issue_op),
      .issueVj_i  (bus.issue_vj),
      .issueQj_i  (bus.issue_qj),
      .issueVk_i  (bus.issue_vk),
      .issueQk_i  (bus.issue_qk),
      .cdbValid_i (bus.cdb_valid),
      .cdbTag_i   (bus.cdb_tag),
      .cdbData_i  (bus.cdb_data),
      .entry_o    (entries[g]),
      .eligible_o (eligVec[g]),
      .busyNext_o (busyNextVec[g])
    );
  end

  // Lowest-index free slot receives the next issue; scanning downward leaves the lowest one.
  always_comb begin
    hasFree  = 1'b0;
    allocIdx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (entries[i].state == FREE) begin
        hasFree  = 1'b1;
        allocIdx = IDX_W'(i);
      end
    end
  end

  // Lowest-index slot whose registered operands are both present is offered to the adder.
  always_comb begin
    hasElig = 1'b0;
    selIdx  = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (eligVec[i]) begin
        hasElig = 1'b1;
        selIdx  = IDX_W'(i);
      end
    end
  end

  assign issueFire = bus.issue_valid && hasFree;
  assign loadOut   = !dispValid_q || bus.disp_ready;

  // Output register refills only when empty or being accepted, so a stalled request holds steady.
  always_comb begin
    dispValid_d = dispValid_q;
    dispOp_d    = dispOp_q;
    dispA_d     = dispA_q;
    dispB_d     = dispB_q;
    dispTag_d   = dispTag_q;
    if (loadOut) begin
      if (hasElig) begin
        dispValid_d = 1'b1;
        dispOp_d    = entries[selIdx].op;
        dispA_d     = entries[selIdx].vj;
        dispB_d     = entries[selIdx].vk;
        dispTag_d   = TAG_W'(TAG_BASE) + TAG_W'(selIdx);
      end else begin
        dispValid_d = 1'b0;
      end
    end
  end

  // Occupancy follows the slots' next states so it changes on the same edge they do.
  always_comb begin
    busyCount_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (busyNextVec[i]) begin
        busyCount_d = busyCount_d + CNT_W'(1);
      end
    end
  end

  // Dispatch and count registers; reset drops any pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      dispValid_q <= 1'b0;
      dispOp_q    <= '0;
      dispA_q     <= '0;
      dispB_q     <= '0;
      dispTag_q   <= '0;
      busyCount_q <= '0;
    end else begin
      dispValid_q <= dispValid_d;
      dispOp_q    <= dispOp_d;
      dispA_q     <= dispA_d;
      dispB_q     <= dispB_d;
      dispTag_q   <= dispTag_d;
      busyCount_q <= busyCount_d;
    end
  end

  assign bus.issue_ready = hasFree;
  assign bus.issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(allocIdx);
  assign bus.disp_valid  = dispValid_q;
  assign bus.disp_op     = dispOp_q;
  assign bus.disp_a      = dispA_q;
  assign bus.disp_b      = dispB_q;
  assign bus.disp_tag    = dispTag_q;
  assign busy_count      = busyCount_q;

endmodule

// File: tb/tb_rs_add_bank.sv
// Directed scoreboard bench for the adder reservation-station bank.
module tb_rs_add_bank;

  import tomasulo_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] busy_count;

  rs_add_bank_if bus();

  rs_add_bank #(
    .NUM_ENTRIES(3),
    .TAG_BASE   (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy_count (busy_count)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  logic [71:0] expQ [$];

  function automatic logic [71:0] pk(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [3:0] tag);
    return {op, a, b, tag};
  endfunction

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setCdb(input logic v, input logic [3:0] tag, input logic [31:0] data);
    bus.cdb_valid = v;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
  endtask

  // Issues one instruction in the current cycle and checks the advertised slot tag.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] vj, input logic [3:0] qj,
                               input logic [31:0] vk, input logic [3:0] qk,
                               input logic [3:0] expTag, input string name);
    bus.issue_valid = 1'b1;
    bus.issue_op    = op;
    bus.issue_vj    = vj;
    bus.issue_qj    = qj;
    bus.issue_vk    = vk;
    bus.issue_qk    = qk;
    @(negedge clk);
    checkOutput({name, " issue_ready"}, 72'(bus.issue_ready), 72'd1);
    checkOutput({name, " issue_tag"}, 72'(bus.issue_tag), 72'(expTag));
    nextCycle();
    bus.issue_valid = 1'b0;
  endtask

  // Monitor: every accepted dispatch must match the oldest expected entry.
  initial begin
    logic [71:0] exp;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.disp_valid === 1'b1 && bus.disp_ready === 1'b1) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected dispatch: got tag %0d a 0x%0h, expected none",
                   bus.disp_tag, bus.disp_a);
        end else begin
          exp = expQ.pop_front();
          checkOutput("dispatch", pk(bus.disp_op, bus.disp_a, bus.disp_b, bus.disp_tag), exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.issue_valid = 1'b0;
    bus.issue_op    = '0;
    bus.issue_vj    = '0;
    bus.issue_qj    = '0;
    bus.issue_vk    = '0;
    bus.issue_qk    = '0;
    bus.disp_ready  = 1'b1;
    setCdb(1'b0, 4'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst disp_valid", 72'(bus.disp_valid), 72'd0);
    checkOutput("rst busy_count", 72'(busy_count), 72'd0);
    checkOutput("rst issue_ready", 72'(bus.issue_ready), 72'd1);
    checkOutput("rst issue_tag", 72'(bus.issue_tag), 72'd1);
    nextCycle();

    // Ready issue: dispatch two cycles later, freed by own tag
    expQ.push_back(pk(4'd1, 32'd5, 32'd7, 4'd1));
    applyStimulus(4'd1, 32'd5, 4'd0, 32'd7, 4'd0, 4'd1, "t1");
    @(negedge clk);
    checkOutput("t1 c1 disp_valid", 72'(bus.disp_valid), 72'd0);
    checkOutput("t1 c1 busy_count", 72'(busy_count), 72'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("t1 c2 disp_valid", 72'(bus.disp_valid), 72'd1);
    nextCycle();
    setCdb(1'b1, 4'd1, 32'd12);
    @(negedge clk);
    checkOutput("t1 c3 disp_valid", 72'(bus.disp_valid), 72'd0);
    checkOutput("t1 c3 busy_count", 72'(busy_count), 72'd1);
    nextCycle();
    setCdb(1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("t1 freed busy_count", 72'(busy_count), 72'd0);
    nextCycle();

    // Snoop: operand j arrives from tag 4
    expQ.push_back(pk(4'd2, 32'h10, 32'd3, 4'd1));
    applyStimulus(4'd2, 32'd0, 4'd4, 32'd3, 4'd0, 4'd1, "t2");
    @(negedge clk);
    checkOutput("t2 c1 disp_valid", 72'(bus.disp_valid), 72'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("t2 c2 disp_valid", 72'(bus.disp_valid), 72'd0);
    nextCycle();
    setCdb(1'b1, 4'd4, 32'h10);
    @(negedge clk);
    checkOutput("t2 c3 disp_valid", 72'(bus.disp_valid), 72'd0);
    nextCycle();
    setCdb(1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("t2 c4 disp_valid", 72'(bus.disp_valid), 72'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("t2 c5 disp_valid", 72'(bus.disp_valid), 72'd1);
    nextCycle();
    setCdb(1'b1, 4'd1, 32'd0);
    nextCycle();
    setCdb(1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("t2 freed busy_count", 72'(busy_count), 72'd0);
    nextCycle();

    // Bypass with both operands matching the broadcast in the issue cycle
    setCdb(1'b1, 4'd6, 32'd9);
    expQ.push_back(pk(4'd3, 32'd9, 32'd9, 4'd1));
    applyStimulus(4'd3, 32'd0, 4'd6, 32'd0, 4'd6, 4'd1, "t3");
    setCdb(1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("t3 c1 disp_valid", 72'(bus.disp_valid), 72'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("t3 c2 disp_valid", 72'(bus.disp_valid), 72'd1);
    nextCycle();
    setCdb(1'b1, 4'd1, 32'd0);
    nextCycle();
    setCdb(1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("t3 freed busy_count", 72'(busy_count), 72'd0);
    nextCycle();

    // Full bank, ignored issue, then free and issue in the same cycle
    expQ.push_back(pk(4'd4, 32'd1, 32'd1, 4'd1));
    applyStimulus(4'd4, 32'd1, 4'd0, 32'd1, 4'd0, 4'd1, "t4a");
    expQ.push_back(pk(4'd4, 32'd2, 32'd2, 4'd2));
    applyStimulus(4'd4, 32'd2, 4'd0, 32'd2, 4'd0, 4'd2, "t4b");
    expQ.push_back(pk(4'd4, 32'd3, 32'd3, 4'd3));
    applyStimulus(4'd4, 32'd3, 4'd0, 32'd3, 4'd0, 4'd3, "t4c");
    bus.issue_valid = 1'b1;
    bus.issue_op    = 4'hF;
    bus.issue_qj    = 4'd0;
    bus.issue_qk    = 4'd0;
    @(negedge clk);
    checkOutput("t4 full issue_ready", 72'(bus.issue_ready), 72'd0);
    checkOutput("t4 full busy_count", 72'(busy_count), 72'd3);
    nextCycle();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    checkOutput("t4 ignored busy_count", 72'(busy_count), 72'd3);
    checkOutput("t4 ignored issue_ready", 72'(bus.issue_ready), 72'd0);
    nextCycle();
    setCdb(1'b1, 4'd2, 32'd0);
    @(negedge clk);
    checkOutput("t4 free-cycle issue_ready", 72'(bus.issue_ready), 72'd0);
    nextCycle();
    setCdb(1'b1, 4'd1, 32'd0);
    expQ.push_back(pk(4'd5, 32'd1, 32'd2, 4'd2));
    applyStimulus(4'd5, 32'd1, 4'd0, 32'd2, 4'd0, 4'd2, "t4 reissue");
    setCdb(1'b1, 4'd3, 32'd0);
    @(negedge clk);
    checkOutput("t4 issue+free busy_count", 72'(busy_count), 72'd2);
    nextCycle();
    setCdb(1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("t4 c8 busy_count", 72'(busy_count), 72'd1);
    checkOutput("t4 c8 disp_valid", 72'(bus.disp_valid), 72'd1);
    nextCycle();
    setCdb(1'b1, 4'd2, 32'd0);
    nextCycle();
    setCdb(1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("t4 freed busy_count", 72'(busy_count), 72'd0);
    nextCycle();

    // Backpressure: held request stays on slot 0, then slot 1 follows
    bus.disp_ready = 1'b0;
    expQ.push_back(pk(4'd6, 32'hA, 32'hB, 4'd1));
    applyStimulus(4'd6, 32'hA, 4'd0, 32'hB, 4'd0, 4'd1, "t5a");
    expQ.push_back(pk(4'd7, 32'hC, 32'hD, 4'd2));
    applyStimulus(4'd7, 32'hC, 4'd0, 32'hD, 4'd0, 4'd2, "t5b");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t5 held disp_valid", 72'(bus.disp_valid), 72'd1);
      checkOutput("t5 held disp_a", 72'(bus.disp_a), 72'hA);
      checkOutput("t5 held disp_tag", 72'(bus.disp_tag), 72'd1);
      nextCycle();
    end
    bus.disp_ready = 1'b1;
    @(negedge clk);
    nextCycle();
    @(negedge clk);
    checkOutput("t5 next disp_tag", 72'(bus.disp_tag), 72'd2);
    nextCycle();
    setCdb(1'b1, 4'd1, 32'd0);
    @(negedge clk);
    checkOutput("t5 drained disp_valid", 72'(bus.disp_valid), 72'd0);
    nextCycle();
    setCdb(1'b1, 4'd2, 32'd0);
    nextCycle();
    setCdb(1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("t5 freed busy_count", 72'(busy_count), 72'd0);
    nextCycle();

    // Reset mid-operation discards slots and the held request
    bus.disp_ready = 1'b0;
    applyStimulus(4'd8, 32'd1, 4'd0, 32'd1, 4'd0, 4'd1, "t6a");
    applyStimulus(4'd9, 32'd2, 4'd0, 32'd2, 4'd0, 4'd2, "t6b");
    @(negedge clk);
    checkOutput("t6 pre-reset disp_valid", 72'(bus.disp_valid), 72'd1);
    nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    bus.disp_ready = 1'b1;
    setCdb(1'b1, 4'd1, 32'd0);
    @(negedge clk);
    checkOutput("t6 post-reset disp_valid", 72'(bus.disp_valid), 72'd0);
    checkOutput("t6 post-reset busy_count", 72'(busy_count), 72'd0);
    checkOutput("t6 post-reset issue_ready", 72'(bus.issue_ready), 72'd1);
    nextCycle();
    setCdb(1'b0, 4'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("t6 idle disp_valid", 72'(bus.disp_valid), 72'd0);
      checkOutput("t6 idle busy_count", 72'(busy_count), 72'd0);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("t6 idle issue_tag", 72'(bus.issue_tag), 72'd1);

    checkOutput("scoreboard drained", 72'(expQ.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
